// File: rtl/spi_mon_pkg.sv
// Shared constants for the SPI monitor capture path: frame start marker, frame length and the
// frame reader's state encoding. The capture-side writer uses the same START_CHAR.
package spi_mon_pkg;

  // Marker byte that opens every capture frame
  localparam logic [7:0] START_CHAR = 8'h20;

  // Start char plus 8 payload bytes (4 x spi_do, 4 x spi_di)
  localparam int unsigned FRAME_BYTES = 9;
  localparam int unsigned DATA_BYTES  = FRAME_BYTES - 1;

  // Reader FSM encoding; *Req states may pop, *Chk/*Cap states consume the popped byte
  localparam logic [2:0] RdHuntReq = 3'd0;
  localparam logic [2:0] RdHuntChk = 3'd1;
  localparam logic [2:0] RdByteReq = 3'd2;
  localparam logic [2:0] RdByteCap = 3'd3;
  localparam logic [2:0] RdPresent = 3'd4;

endpackage

// File: rtl/spi_frame_reader.sv
// Consumer side of the SPI monitor capture FIFO. Hunts for the start char, assembles the next
// 8 bytes into {spi_do, spi_di} words and offers them on a valid/ready interface. Frames that
// stall mid-way are dropped and the reader re-synchronises on the next start char.
// Optional build macro: SPI_FRAME_STATS_EN adds frameCount/errCount statistics ports.
module spi_frame_reader
  import spi_mon_pkg::*;
#(
  parameter logic [7:0]  StartChar  = START_CHAR,
  parameter int unsigned TimeoutCyc = 1024,
  parameter int unsigned ToWidth    = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fifoDataOut,
  input  logic        fifoEmpty,
  output logic        fifoREn,
  output logic        frameValid,
  input  logic        frameReady,
  output logic [31:0] frameDo,
  output logic [31:0] frameDi,
  output logic        syncErr
`ifdef SPI_FRAME_STATS_EN
  ,
  output logic [15:0] frameCount,
  output logic [15:0] errCount
`endif
);

  localparam logic [ToWidth-1:0] ToLast  = ToWidth'(TimeoutCyc - 1);
  localparam logic [2:0]         LastIdx = 3'(DATA_BYTES - 1);

  logic [2:0]         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [ToWidth-1:0] to_q, to_d;
  // Holds the first 7 payload bytes; the 8th is merged straight into the output words
  logic [55:0]        shift_q, shift_d;
  logic [31:0]        do_q, do_d;
  logic [31:0]        di_q, di_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               ren;

  // Next-state decode: hunt, request/capture payload bytes, then hold the frame until taken
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    to_d    = to_q;
    shift_d = shift_q;
    do_d    = do_q;
    di_d    = di_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    ren     = 1'b0;
    case (state_q)
      RdHuntReq: begin
        if (!fifoEmpty) begin
          ren     = 1'b1;
          state_d = RdHuntChk;
        end
      end
      RdHuntChk: begin
        if (fifoDataOut == StartChar) begin
          idx_d   = '0;
          to_d    = '0;
          state_d = RdByteReq;
        end else begin
          err_d   = 1'b1;
          state_d = RdHuntReq;
        end
      end
      RdByteReq: begin
        if (!fifoEmpty) begin
          ren     = 1'b1;
          to_d    = '0;
          state_d = RdByteCap;
        end else if (to_q == ToLast) begin
          // Writer stalled mid-frame: drop the partial frame and hunt again
          err_d   = 1'b1;
          to_d    = '0;
          state_d = RdHuntReq;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      RdByteCap: begin
        shift_d = {shift_q[47:0], fifoDataOut};
        if (idx_q == LastIdx) begin
          do_d    = shift_q[55:24];
          di_d    = {shift_q[23:0], fifoDataOut};
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = RdPresent;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = RdByteReq;
        end
      end
      RdPresent: begin
        if (frameReady) begin
          valid_d = 1'b0;
          state_d = RdHuntReq;
        end
      end
      default: begin
        state_d = RdHuntReq;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RdHuntReq;
      idx_q   <= '0;
      to_q    <= '0;
      shift_q <= '0;
      do_q    <= '0;
      di_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      shift_q <= shift_d;
      do_q    <= do_d;
      di_q    <= di_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Pop strobe is decoded from state; masked by rst so every output is low while in reset
  assign fifoREn    = ren & ~rst;
  assign frameValid = valid_q;
  assign frameDo    = do_q;
  assign frameDi    = di_q;
  assign syncErr    = err_q;

`ifdef SPI_FRAME_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  // Free-running wrap-around counters of delivered frames and sync errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (valid_q && frameReady) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_q)                 err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign frameCount = frame_cnt_q;
  assign errCount   = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_frame_reader.sv
// Self-checking bench for spi_frame_reader: a queue-based FIFO model feeds bytes, a monitor
// records delivered frames, error pulses and protocol violations, and a stream parser
// predicts which frames and how many sync errors a byte stream must produce.
`timescale 1ns/1ps
module tb_spi_frame_reader;

  localparam int unsigned TimeoutCyc = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fifoDataOut;
  logic        fifoEmpty;
  logic        fifoREn;
  logic        frameValid;
  logic        frameReady;
  logic [31:0] frameDo;
  logic [31:0] frameDi;
  logic        syncErr;
`ifdef SPI_FRAME_STATS_EN
  logic [15:0] frameCount;
  logic [15:0] errCount;
`endif

  always #5 clk = ~clk;

  spi_frame_reader dut (
    .clk         (clk),
    .rst         (rst),
    .fifoDataOut (fifoDataOut),
    .fifoEmpty   (fifoEmpty),
    .fifoREn     (fifoREn),
    .frameValid  (frameValid),
    .frameReady  (frameReady),
    .frameDo     (frameDo),
    .frameDi     (frameDi),
    .syncErr     (syncErr)
`ifdef SPI_FRAME_STATS_EN
    ,
    .frameCount  (frameCount),
    .errCount    (errCount)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // FIFO model: pending pushes land at the next edge, pops return data the cycle after fifoREn
  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] stim_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (fifoREn && fifo_q.size() != 0) fifoDataOut <= fifo_q.pop_front();
    while (pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
    fifoEmpty <= (fifo_q.size() == 0);
  end

  // Monitor sampled mid-cycle
  int err_cnt = 0, err_since_rst = 0, hs_since_rst = 0, viol = 0;
  int last_err_cyc = 0, last_ren_cyc = 0;
  logic prev_valid = 1'b0, prev_hs = 1'b0, prev_ren = 1'b0, prev_err = 1'b0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0; prev_hs = 1'b0; prev_ren = 1'b0; prev_err = 1'b0;
      hs_since_rst = 0; err_since_rst = 0;
    end else begin
      if (fifoREn && fifoEmpty) viol++;
      if (fifoREn && prev_ren) viol++;
      if (syncErr && prev_err) viol++;
      if (prev_valid && !prev_hs && (!frameValid || {frameDo, frameDi} !== prev_data)) viol++;
      if (syncErr) begin
        err_cnt++; err_since_rst++; last_err_cyc = cyc;
      end
      if (fifoREn) last_ren_cyc = cyc;
      prev_hs = frameValid && frameReady;
      if (prev_hs) begin
        obs_q.push_back({frameDo, frameDi});
        hs_since_rst++;
      end
      prev_valid = frameValid;
      prev_ren   = fifoREn;
      prev_err   = syncErr;
      prev_data  = {frameDo, frameDi};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    pend_q.push_back(b);
    stim_q.push_back(b);
  endtask

  // Push the n most-significant-first bytes held in the low n*8 bits of v
  task automatic push_vec(input logic [71:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) push_byte(v[i*8 +: 8]);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int b = budget;
    while (obs_q.size() < target && b > 0) begin
      tick();
      b--;
    end
  endtask

  // Stream parser: non-start bytes between frames are errors, a start char claims the next 8
  function automatic int model_run();
    int errs = 0;
    int i = 0;
    exp_q.delete();
    while (i < stim_q.size()) begin
      if (stim_q[i] != 8'h20) begin
        errs++;
        i++;
      end else if (i + 8 < stim_q.size()) begin
        logic [63:0] f;
        f = '0;
        for (int k = 1; k <= 8; k++) f = {f[55:0], stim_q[i+k]};
        exp_q.push_back(f);
        i += 9;
      end else begin
        i = stim_q.size();
      end
    end
    return errs;
  endfunction

  function automatic logic [63:0] obs_at(input int idx);
    if (obs_q.size() > idx) return obs_q[idx];
    return 'x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    frameReady = 1'b0;
    push_byte(8'h55);
    tick(); tick(); tick();
    @(negedge clk);
    n_checks++; if (fifoREn !== 1'b0) $display("FAIL reset_fifoREn got=%b want=0", fifoREn); else n_pass++;
    n_checks++; if (frameValid !== 1'b0) $display("FAIL reset_frameValid got=%b want=0", frameValid); else n_pass++;
    n_checks++; if (syncErr !== 1'b0) $display("FAIL reset_syncErr got=%b want=0", syncErr); else n_pass++;
    n_checks++; if (frameDo !== 32'h0) $display("FAIL reset_frameDo got=%h want=0", frameDo); else n_pass++;
    n_checks++; if (frameDi !== 32'h0) $display("FAIL reset_frameDi got=%h want=0", frameDi); else n_pass++;
    fifo_q.delete();
    stim_q.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    int base = obs_q.size();
    int e0 = err_cnt;
    frameReady = 1'b1;
    stim_q.delete();
    push_vec(72'h20_11_22_33_44_A1_B2_C3_D4, 9);
    wait_frames(base + 1, 200);
    tick(); tick();
    n_checks++; if (obs_q.size() !== base + 1) $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), base + 1); else n_pass++;
    n_checks++; if (obs_at(base) !== 64'h11223344_A1B2C3D4) $display("FAIL basic_frame got=%h want=11223344a1b2c3d4", obs_at(base)); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL basic_syncerr got=%0d want=0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_resync();
    int base = obs_q.size();
    int e0 = err_cnt;
    int exp_errs;
    stim_q.delete();
    push_vec(72'h55_66, 2);
    push_vec(72'h20_01_23_45_67_89_AB_CD_EF, 9);
    exp_errs = model_run();
    wait_frames(base + 1, 200);
    tick(); tick();
    n_checks++; if (err_cnt - e0 !== exp_errs) $display("FAIL resync_errs got=%0d want=%0d", err_cnt - e0, exp_errs); else n_pass++;
    n_checks++; if (obs_at(base) !== exp_q[0]) $display("FAIL resync_frame got=%h want=%h", obs_at(base), exp_q[0]); else n_pass++;
  endtask

  task automatic test_start_in_data();
    int base = obs_q.size();
    int e0 = err_cnt;
    stim_q.delete();
    push_vec(72'h20_20_00_00_01_20_FF_FF_20, 9);
    wait_frames(base + 1, 200);
    tick(); tick(); tick(); tick();
    n_checks++; if (obs_at(base) !== 64'h20000001_20FFFF20) $display("FAIL startdata_frame got=%h want=2000000120ffff20", obs_at(base)); else n_pass++;
    n_checks++; if (obs_q.size() !== base + 1) $display("FAIL startdata_count got=%0d want=%0d", obs_q.size(), base + 1); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL startdata_syncerr got=%0d want=0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_backpressure();
    int base = obs_q.size();
    int bad = 0;
    int b = 100;
    logic [63:0] held;
    frameReady = 1'b0;
    stim_q.delete();
    push_vec(72'h20_DE_AD_BE_EF_01_23_45_67, 9);
    push_byte(8'h20);
    for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
    void'(model_run());
    while (!frameValid && b > 0) begin
      tick();
      b--;
    end
    @(negedge clk);
    n_checks++; if (frameValid !== 1'b1) $display("FAIL bp_valid_rise got=%b want=1", frameValid); else n_pass++;
    held = {frameDo, frameDi};
    n_checks++; if (held !== exp_q[0]) $display("FAIL bp_first_frame got=%h want=%h", held, exp_q[0]); else n_pass++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!frameValid || fifoREn || {frameDo, frameDi} !== held) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL bp_hold_cycles got=%0d bad want=0", bad); else n_pass++;
    n_checks++; if (fifo_q.size() !== 9) $display("FAIL bp_fifo_level got=%0d want=9", fifo_q.size()); else n_pass++;
    tick();
    frameReady = 1'b1;
    wait_frames(base + 2, 200);
    n_checks++; if (obs_at(base) !== exp_q[0]) $display("FAIL bp_frame0 got=%h want=%h", obs_at(base), exp_q[0]); else n_pass++;
    n_checks++; if (obs_at(base + 1) !== exp_q[1]) $display("FAIL bp_frame1 got=%h want=%h", obs_at(base + 1), exp_q[1]); else n_pass++;
  endtask

  task automatic test_timeout();
    int base = obs_q.size();
    int e0 = err_cnt;
    int b = TimeoutCyc + 200;
    int gap;
    frameReady = 1'b1;
    stim_q.delete();
    push_vec(72'h20_01_02, 3);
    while (err_cnt == e0 && b > 0) begin
      tick();
      b--;
    end
    tick();
    gap = last_err_cyc - last_ren_cyc;
    n_checks++; if (err_cnt - e0 !== 1) $display("FAIL timeout_err got=%0d want=1", err_cnt - e0); else n_pass++;
    // TimeoutCyc empty request cycles after the capture cycle, plus the pulse register
    n_checks++;
    if (gap < TimeoutCyc + 1 || gap > TimeoutCyc + 2)
      $display("FAIL timeout_delay got=%0d want=%0d..%0d", gap, TimeoutCyc + 1, TimeoutCyc + 2);
    else n_pass++;
    n_checks++; if (obs_q.size() !== base) $display("FAIL timeout_noframe got=%0d want=%0d", obs_q.size(), base); else n_pass++;
    stim_q.delete();
    push_vec(72'h20_CA_FE_BA_BE_12_34_56_78, 9);
    wait_frames(base + 1, 200);
    n_checks++; if (obs_at(base) !== 64'hCAFEBABE_12345678) $display("FAIL timeout_next_frame got=%h want=cafebabe12345678", obs_at(base)); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int base;
    int e0;
    int b = 100;
    frameReady = 1'b1;
    stim_q.delete();
    push_vec(72'h20_AA_BB_CC_DD, 5);
    while ((fifo_q.size() != 0 || pend_q.size() != 0) && b > 0) begin
      tick();
      b--;
    end
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_checks++; if (frameDo !== 32'h0 || frameDi !== 32'h0) $display("FAIL midrst_data got=%h%h want=0", frameDo, frameDi); else n_pass++;
    n_checks++; if (frameValid !== 1'b0 || syncErr !== 1'b0 || fifoREn !== 1'b0) $display("FAIL midrst_ctrl got=%b%b%b want=000", frameValid, syncErr, fifoREn); else n_pass++;
    tick(); tick();
    rst = 1'b0;
    tick();
    base = obs_q.size();
    e0 = err_cnt;
    stim_q.delete();
    push_vec(72'h20_0F_1E_2D_3C_4B_5A_69_78, 9);
    wait_frames(base + 1, 200);
    tick(); tick();
    n_checks++; if (obs_at(base) !== 64'h0F1E2D3C_4B5A6978) $display("FAIL midrst_frame got=%h want=0f1e2d3c4b5a6978", obs_at(base)); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL midrst_syncerr got=%0d want=0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      int base = obs_q.size();
      int e0 = err_cnt;
      int exp_errs;
      int b = 3000;
      stim_q.delete();
      for (int f = 0; f < 6; f++) begin
        int noise = $urandom_range(0, 2);
        for (int k = 0; k < noise; k++) begin
          logic [7:0] nb;
          nb = 8'($urandom_range(0, 255));
          if (nb == 8'h20) nb = 8'h21;
          push_byte(nb);
        end
        push_byte(8'h20);
        for (int k = 0; k < 8; k++) push_byte(8'($urandom_range(0, 255)));
      end
      exp_errs = model_run();
      while (obs_q.size() < base + 6 && b > 0) begin
        tick();
        frameReady = 1'($urandom_range(0, 1));
        b--;
      end
      frameReady = 1'b1;
      tick(); tick();
      n_checks++; if (obs_q.size() !== base + 6) $display("FAIL b2b_count round=%0d got=%0d want=%0d", r, obs_q.size() - base, 6); else n_pass++;
      for (int f = 0; f < 6; f++) begin
        n_checks++;
        if (obs_at(base + f) !== exp_q[f]) $display("FAIL b2b_frame round=%0d idx=%0d got=%h want=%h", r, f, obs_at(base + f), exp_q[f]);
        else n_pass++;
      end
      n_checks++; if (err_cnt - e0 !== exp_errs) $display("FAIL b2b_errs round=%0d got=%0d want=%0d", r, err_cnt - e0, exp_errs); else n_pass++;
    end
  endtask

  task automatic test_protocol();
    tick();
    n_checks++; if (viol !== 0) $display("FAIL protocol_violations got=%0d want=0", viol); else n_pass++;
  endtask

`ifdef SPI_FRAME_STATS_EN
  task automatic test_stats();
    tick(); tick();
    @(negedge clk);
    n_checks++; if (frameCount !== 16'(hs_since_rst)) $display("FAIL stats_frames got=%0d want=%0d", frameCount, hs_since_rst); else n_pass++;
    n_checks++; if (errCount !== 16'(err_since_rst)) $display("FAIL stats_errs got=%0d want=%0d", errCount, err_since_rst); else n_pass++;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    frameReady  = 1'b0;
    fifoEmpty   = 1'b1;
    fifoDataOut = 8'h00;
    test_reset();
    test_basic_frame();
    test_resync();
    test_start_in_data();
    test_backpressure();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
`ifdef SPI_FRAME_STATS_EN
    test_stats();
`endif
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=time_limit want=finish passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
